// File: rtl/crypto_ctrl_pkg.sv
// Shared types and constants for the crypto-processor sequencer.
package crypto_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOAD_WAIT,
      ST_PC_RST,
      ST_FETCH,
      ST_DECODE,
      ST_WAIT_START,
      ST_EXEC,
      ST_DRD,
      ST_DWR,
      ST_HALT
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_LDD  = 5'd1;
   localparam logic [4:0] OP_STD  = 5'd2;
   localparam logic [4:0] OP_BR   = 5'd3;
   localparam logic [4:0] OP_HALT = 5'd31;

   localparam logic [1:0] PTR_EMPTY = 2'd0;
   localparam logic [1:0] PTR_FULL  = 2'd3;

   // Block count for LDD/STD: operand field plus one, widened so 15 -> 16 fits.
   function automatic logic [4:0] blk_count(input logic [3:0] addr);
      return {1'b0, addr} + 5'd1;
   endfunction

endpackage

// File: rtl/crypto_seq_ctrl.sv
// Fetch/decode/execute sequencer driving the crypto datapath strobes.
// All outputs are registered; each strobe is a single-cycle pulse that
// appears in the cycle after the state that issues it.
module crypto_seq_ctrl
   import crypto_ctrl_pkg::*;
#(
   parameter int unsigned PROG_LEN = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       prog_valid,
   output logic       prog_ready,
   input  logic [4:0] opcode,
   input  logic [3:0] operand_addr,
   input  logic [1:0] operand_addr_mode,
   input  logic       start,
   input  logic       instr_written,
   input  logic [1:0] ptr_diff,
   output logic       incr_pc,
   output logic       branch_offset_en,
   output logic       reset_pc,
   output logic       incr_pc_write,
   output logic       read_data,
   output logic       write_data,
   output logic       instrn_decode,
   output logic       read_flag,
   output logic       write_flag,
   output logic       incr_data_read,
   output logic       incr_data_write,
   output logic       busy,
   output logic       halted,
   output logic       err
);

   localparam logic [14:0] LAST_WORD = 15'(PROG_LEN - 1);

   state_t      r_state;
   logic [14:0] r_word;
   logic [4:0]  r_blk;
   logic [4:0]  r_opcode;
   logic [3:0]  r_operand;

   logic r_prog_ready;
   logic r_incr_pc;
   logic r_branch_offset_en;
   logic r_reset_pc;
   logic r_incr_pc_write;
   logic r_read_data;
   logic r_write_data;
   logic r_instrn_decode;
   logic r_read_flag;
   logic r_write_flag;
   logic r_incr_data_read;
   logic r_incr_data_write;
   logic r_busy;
   logic r_halted;
   logic r_err;

   // Addressing mode is decoded upstream but not acted on in this revision.
   logic w_unused_mode;
   assign w_unused_mode = ^operand_addr_mode;

   // Sequencer: next state, counters and registered strobes/status in one block.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state            <= ST_IDLE;
         r_word             <= '0;
         r_blk              <= '0;
         r_opcode           <= '0;
         r_operand          <= '0;
         r_prog_ready       <= 1'b0;
         r_incr_pc          <= 1'b0;
         r_branch_offset_en <= 1'b0;
         r_reset_pc         <= 1'b0;
         r_incr_pc_write    <= 1'b0;
         r_read_data        <= 1'b0;
         r_write_data       <= 1'b0;
         r_instrn_decode    <= 1'b0;
         r_read_flag        <= 1'b0;
         r_write_flag       <= 1'b0;
         r_incr_data_read   <= 1'b0;
         r_incr_data_write  <= 1'b0;
         r_busy             <= 1'b0;
         r_halted           <= 1'b0;
         r_err              <= 1'b0;
      end else begin
         r_prog_ready       <= 1'b0;
         r_incr_pc          <= 1'b0;
         r_branch_offset_en <= 1'b0;
         r_reset_pc         <= 1'b0;
         r_incr_pc_write    <= 1'b0;
         r_read_data        <= 1'b0;
         r_write_data       <= 1'b0;
         r_instrn_decode    <= 1'b0;
         r_read_flag        <= 1'b0;
         r_write_flag       <= 1'b0;
         r_incr_data_read   <= 1'b0;
         r_incr_data_write  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  r_word  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (prog_valid) begin
                  r_write_data    <= 1'b1;
                  r_incr_pc_write <= 1'b1;
                  r_prog_ready    <= 1'b1;
                  r_state         <= ST_LOAD_WAIT;
               end
            end

            ST_LOAD_WAIT: begin
               if (instr_written) begin
                  if (r_word == LAST_WORD) begin
                     r_state <= ST_PC_RST;
                  end else begin
                     r_word  <= r_word + 15'd1;
                     r_state <= ST_LOAD;
                  end
               end
            end

            ST_PC_RST: begin
               r_reset_pc <= 1'b1;
               r_state    <= ST_FETCH;
            end

            ST_FETCH: begin
               r_read_data <= 1'b1;
               r_state     <= ST_DECODE;
            end

            ST_DECODE: begin
               r_instrn_decode <= 1'b1;
               r_state         <= ST_WAIT_START;
            end

            ST_WAIT_START: begin
               if (start) begin
                  r_opcode  <= opcode;
                  r_operand <= operand_addr;
                  r_state   <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               case (r_opcode)
                  OP_NOP: begin
                     r_incr_pc <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
                  OP_LDD: begin
                     r_blk   <= blk_count(r_operand);
                     r_state <= ST_DRD;
                  end
                  OP_STD: begin
                     r_blk   <= blk_count(r_operand);
                     r_state <= ST_DWR;
                  end
                  OP_BR: begin
                     r_branch_offset_en <= 1'b1;
                     r_state            <= ST_FETCH;
                  end
                  OP_HALT: begin
                     r_busy   <= 1'b0;
                     r_halted <= 1'b1;
                     r_state  <= ST_HALT;
                  end
                  default: begin
                     r_err     <= 1'b1;
                     r_incr_pc <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               endcase
            end

            // The PC advance rides with the final transfer so an N-block
            // burst costs exactly N cycles in this state.
            ST_DRD: begin
               if (ptr_diff != PTR_EMPTY) begin
                  r_read_flag      <= 1'b1;
                  r_incr_data_read <= 1'b1;
                  r_blk            <= r_blk - 5'd1;
                  if (r_blk == 5'd1) begin
                     r_incr_pc <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               end
            end

            ST_DWR: begin
               if (ptr_diff != PTR_FULL) begin
                  r_write_flag      <= 1'b1;
                  r_incr_data_write <= 1'b1;
                  r_blk             <= r_blk - 5'd1;
                  if (r_blk == 5'd1) begin
                     r_incr_pc <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               end
            end

            ST_HALT: begin
               if (go) begin
                  r_word   <= '0;
                  r_halted <= 1'b0;
                  r_err    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_LOAD;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign prog_ready       = r_prog_ready;
   assign incr_pc          = r_incr_pc;
   assign branch_offset_en = r_branch_offset_en;
   assign reset_pc         = r_reset_pc;
   assign incr_pc_write    = r_incr_pc_write;
   assign read_data        = r_read_data;
   assign write_data       = r_write_data;
   assign instrn_decode    = r_instrn_decode;
   assign read_flag        = r_read_flag;
   assign write_flag       = r_write_flag;
   assign incr_data_read   = r_incr_data_read;
   assign incr_data_write  = r_incr_data_write;
   assign busy             = r_busy;
   assign halted           = r_halted;
   assign err              = r_err;

endmodule
